dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data BRAM between the RISC-V core's load/store port and a DMA/loader requester.
- Grants one requester per cycle, combinationally in the same cycle as the request. The Execute stage can then issue without an extra register stage.
- Routes the 1-cycle-latency read data back to whichever requester issued the read.
- Drives a stall (hold) into the core pipeline whenever a core request is not granted. Supports DMA burst locking with a bounded burst length so the core is never starved.

Parameters:
- AWIDTH, 14, word-address width of the data memory.
- DWIDTH, 32, data width.
- MAX_BURST, 4, maximum consecutive contended DMA grants while dma_lock is held; must be 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- core_req  in  1  core memory access request
- core_we  in  4  core byte write enables (0000 = read)
- core_addr  in  AWIDTH  core word address
- core_wdata  in  DWIDTH  core write data
- core_gnt  out  1  core access accepted this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DWIDTH  read data to core
- hold  out  1  pipeline stall, = core_req & ~core_gnt
- dma_req  in  1  DMA request
- dma_lock  in  1  DMA requests burst priority
- dma_we  in  4  DMA byte write enables
- dma_addr  in  AWIDTH  DMA word address
- dma_wdata  in  DWIDTH  DMA write data
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DWIDTH  read data to DMA
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  AWIDTH  BRAM address
- mem_wdata  out  DWIDTH  BRAM write data
- mem_rdata  in  DWIDTH  BRAM read data, valid 1 cycle after a read

Behaviour:
- Registered state:
  - last_owner (NONE/CORE/DMA)
  - dma_gnt_q
  - burst_cnt (4 bits, saturating at MAX_BURST)
  - rd_valid_q
  - rd_owner_q
- Reset values: last_owner=NONE, dma_gnt_q=0, burst_cnt=0, rd_valid_q=0, rd_owner_q=CORE.
- While rst=0: core_gnt=dma_gnt=0, hold=core_req, mem_en=0, mem_we=0, rvalids=0.
- Grant (combinational):
  - Only one request active: grant it.
  - Both active, with dma_lock=1, dma_gnt_q=1 and burst_cnt<MAX_BURST: grant DMA.
  - Both active, otherwise: round-robin. Grant the requester that is not last_owner; if last_owner=NONE, grant CORE.
  - No request: no grant.
- Grants are mutually exclusive.
- last_owner updates only on a grant; it holds through idle cycles.
- burst_cnt:
  - DMA granted with dma_gnt_q=0 → 1.
  - DMA granted with dma_gnt_q=1 → +1, saturating at MAX_BURST.
  - DMA not granted → 0.
- Memory mux:
  - mem_en=core_gnt|dma_gnt.
  - mem_we/addr/wdata come from the granted requester.
  - With no grant, mem_we=0 and mem_addr=mem_wdata=0.
  - A write is never issued without a grant.
- Read tracking: a read is a grant with we==0000. On the next edge, rd_valid_q<=read and rd_owner_q<=granted requester.
- Response:
  - core_rvalid=rd_valid_q&(rd_owner_q==CORE); dma_rvalid=rd_valid_q&(rd_owner_q==DMA).
  - core_rdata and dma_rdata both = mem_rdata; the rvalids qualify them.
- Write latency: 0 extra cycles; writes have no response.
- Back-to-back reads from alternating requesters are supported. Each response arrives exactly 1 cycle after its grant.
- A requester must hold req/addr/we/wdata stable until granted; the arbiter never latches an ungranted request.
- Reset asserted mid-read: the pending response is dropped (rvalid never pulses). After release, CORE wins the first contended cycle.
- dma_lock asserted without dma_req has no effect.

Decomposition:
- Shared package holds:
  - owner encoding: NONE=2'b00, CORE=2'b01, DMA=2'b10
  - BRAM write-enable constants: WE_NONE=4'b0000, WE_WORD=4'b1111
- One natural sub-module: rr_grant2. It is the combinational two-way round-robin/lock pick, with inputs req[1:0], last_owner, lock_ok and output gnt[1:0].
- Counters, read tracking and the memory mux stay in the top module.

Test Plan:
1. Core-only read: release reset, core_req=1, core_we=0, core_addr=0x010. Expect:
   - same cycle: core_gnt=1, mem_en=1, mem_addr=0x010, hold=0.
   - next cycle: core_rvalid=1, core_rdata=mem_rdata, dma_rvalid=0.
2. Contention without lock: both requesting reads for 4 cycles after reset. Expect:
   - grants CORE, DMA, CORE, DMA.
   - hold=1 in cycles 2 and 4.
   - rvalids alternate one cycle later.
3. Burst lock, MAX_BURST=4: DMA requests alone with dma_lock=1 for 1 cycle, then core joins and both stay requesting. Expect:
   - grants D, D, D, D, C, D, D, D, D, C.
   - burst_cnt peaks at 4; the core is never stalled more than 4 cycles.
4. Write/read mix: after reset, core write we=4'b0011 addr 0x020 data 0xDEADBEEF together with a DMA read of 0x020. Expect:
   - cycle 1: core_gnt, mem_we=0011.
   - cycle 2: dma_gnt, mem_we=0000.
   - cycle 3: dma_rvalid=1, core_rvalid=0.
5. Reset mid-read: DMA read granted, then rst=0 before the next edge. Expect:
   - dma_rvalid never asserts.
   - after release, contended cycle grants CORE.
6. Idle: no requests for 3 cycles. Expect mem_en=0, mem_we=0, both rvalids 0, and last_owner preserved (next contended grant goes to the non-last owner).

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   owner_t  : which requester owns a grant or a pending read response
//   WE_*     : BRAM byte-write-enable constants
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_DMA  = 2'b10
  } owner_t;

  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_WORD = 4'b1111;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin pick with a DMA lock override. Purely combinational.
// Ports:
//   req        : bit 0 = core request, bit 1 = DMA request
//   last_owner : requester that received the most recent grant
//   lock_ok    : DMA burst lock may still win a contended cycle
//   gnt        : one-hot (or zero) grant, same bit order as req
module rr_grant2
  import dmem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  input  logic       lock_ok,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        // With no history (NONE) the core wins, so only CORE as last owner
        // hands a contended cycle to the DMA without the lock.
        if (lock_ok || (last_owner == OWN_CORE)) gnt = 2'b10;
        else                                     gnt = 2'b01;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data BRAM between the core load/store port and a
// DMA/loader. Grants are combinational in the request cycle; read data comes
// back one cycle after the grant and is steered by a registered owner tag.
// Ports:
//   clk, rst                 : clock, async active-low reset
//   core_*                   : core request/grant/response, hold = core stall
//   dma_*                    : DMA request (with burst lock)/grant/response
//   mem_*                    : BRAM port (mem_rdata valid 1 cycle after read)
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AWIDTH    = 14,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              core_req,
  input  logic [3:0]        core_we,
  input  logic [AWIDTH-1:0] core_addr,
  input  logic [DWIDTH-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DWIDTH-1:0] core_rdata,
  output logic              hold,

  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic [3:0]        dma_we,
  input  logic [AWIDTH-1:0] dma_addr,
  input  logic [DWIDTH-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DWIDTH-1:0] dma_rdata,

  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  owner_t      last_owner;
  owner_t      rd_owner_q;
  logic        dma_gnt_q;
  logic [3:0]  burst_cnt;
  logic        rd_valid_q;

  logic        lock_ok;
  logic [1:0]  pick;
  logic        is_read;

  assign lock_ok = dma_lock & dma_gnt_q & (burst_cnt < BURST_MAX);

  rr_grant2 u_rr_grant2 (
    .req        ({dma_req, core_req}),
    .last_owner (last_owner),
    .lock_ok    (lock_ok),
    .gnt        (pick)
  );

  // Grants are masked while reset is asserted so no access leaks out during
  // the asynchronous reset window.
  assign core_gnt = rst & pick[0];
  assign dma_gnt  = rst & pick[1];
  assign hold     = core_req & ~core_gnt;

  always_comb begin
    mem_en    = core_gnt | dma_gnt;
    mem_we    = WE_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign is_read = (core_gnt && (core_we == WE_NONE)) ||
                   (dma_gnt  && (dma_we  == WE_NONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWN_NONE;
      dma_gnt_q  <= 1'b0;
      burst_cnt  <= 4'd0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      if (core_gnt)     last_owner <= OWN_CORE;
      else if (dma_gnt) last_owner <= OWN_DMA;

      dma_gnt_q <= dma_gnt;

      if (!dma_gnt)                    burst_cnt <= 4'd0;
      else if (!dma_gnt_q)             burst_cnt <= 4'd1;
      else if (burst_cnt < BURST_MAX)  burst_cnt <= burst_cnt + 4'd1;

      rd_valid_q <= is_read;
      if (core_gnt)     rd_owner_q <= OWN_CORE;
      else if (dma_gnt) rd_owner_q <= OWN_DMA;
    end
  end

  assign core_rvalid = rd_valid_q & (rd_owner_q == OWN_CORE);
  assign dma_rvalid  = rd_valid_q & (rd_owner_q == OWN_DMA);
  assign core_rdata  = mem_rdata;
  assign dma_rdata   = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a
// behavioural model and a shadow copy of the BRAM contents.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_gnt, core_rvalid, hold;
  logic [3:0]    core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          dma_req, dma_lock, dma_gnt, dma_rvalid;
  logic [3:0]    dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .hold(hold),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // BRAM behind the DUT, and a shadow copy the model writes on its own grants
  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic [DW-1:0] sh   [0:(1<<AW)-1];

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      bram[i] = 32'hA500_0000 | i;
      sh[i]   = 32'hA500_0000 | i;
    end
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == WE_NONE) mem_rdata <= bram[mem_addr];
      else
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // who: 0 = nobody, 1 = core, 2 = dma
  int            m_last  = 0;
  int            m_burst = 0;
  bit            m_prevd = 0;
  bit            m_pend  = 0;
  int            m_pown  = 1;
  logic [DW-1:0] m_pdata = '0;
  bit            m_cg = 0, m_dg = 0;
  int            stall_run = 0;

  int            who;
  bit            n_pend;
  logic [DW-1:0] n_pdata;
  logic [3:0]    e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always begin
    @(negedge clk);
    if (!rst) begin
      m_last = 0; m_burst = 0; m_prevd = 0; m_pend = 0; m_pown = 1;
    end
    if (!rst)                   who = 0;
    else if (core_req && dma_req) begin
      if (dma_lock && m_prevd && m_burst < MB) who = 2;
      else                                      who = (m_last == 1) ? 2 : 1;
    end
    else if (core_req)          who = 1;
    else if (dma_req)           who = 2;
    else                        who = 0;

    e_we    = (who == 1) ? core_we    : (who == 2) ? dma_we    : 4'b0000;
    e_addr  = (who == 1) ? core_addr  : (who == 2) ? dma_addr  : '0;
    e_wdata = (who == 1) ? core_wdata : (who == 2) ? dma_wdata : '0;

    chk("core_gnt",    core_gnt,   32'(who == 1));
    chk("dma_gnt",     dma_gnt,    32'(who == 2));
    chk("hold",        hold,       32'(core_req && who != 1));
    chk("mem_en",      mem_en,     32'(who != 0));
    chk("mem_we",      mem_we,     e_we);
    chk("mem_addr",    mem_addr,   e_addr);
    chk("mem_wdata",   mem_wdata,  e_wdata);
    chk("core_rvalid", core_rvalid, 32'(rst && m_pend && m_pown == 1));
    chk("dma_rvalid",  dma_rvalid,  32'(rst && m_pend && m_pown == 2));
    if (rst && m_pend && m_pown == 1) chk("core_rdata", core_rdata, m_pdata);
    if (rst && m_pend && m_pown == 2) chk("dma_rdata",  dma_rdata,  m_pdata);

    if (rst && hold) stall_run++;
    else begin
      if (stall_run > 0 && rst) chk("stall_bound", 32'(stall_run <= MB), 32'd1);
      stall_run = 0;
    end

    m_cg    = (who == 1);
    m_dg    = (who == 2);
    n_pend  = (who != 0) && (e_we == 4'b0000);
    n_pdata = sh[e_addr];

    @(posedge clk);
    if (rst) begin
      if (who != 0 && e_we != 4'b0000)
        for (int b = 0; b < 4; b++)
          if (e_we[b]) sh[e_addr][8*b +: 8] = e_wdata[8*b +: 8];
      if (who == 2) m_burst = m_prevd ? ((m_burst < MB) ? m_burst + 1 : MB) : 1;
      else          m_burst = 0;
      m_prevd = (who == 2);
      if (who != 0) m_last = who;
      m_pend  = n_pend;
      if (who != 0) m_pown = who;
      m_pdata = n_pdata;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_reqs();
    step();
    step();
    rst = 1;
  endtask

  task automatic new_core();
    int r;
    r = $urandom_range(0, 3);
    core_req   = 1;
    core_we    = (r < 2) ? 4'b0000 : (r == 2) ? WE_WORD : 4'($urandom_range(1, 15));
    core_addr  = AW'($urandom_range(0, 15));
    core_wdata = $urandom;
  endtask

  task automatic new_dma();
    int r;
    r = $urandom_range(0, 3);
    dma_req   = 1;
    dma_we    = (r < 2) ? 4'b0000 : (r == 2) ? WE_WORD : 4'($urandom_range(1, 15));
    dma_addr  = AW'($urandom_range(0, 15));
    dma_wdata = $urandom;
  endtask

  int exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    rst = 0;
    clear_reqs();
    core_req = 1; core_addr = 14'h010;

    // reset state
    @(negedge clk);
    chk("rst_hold",     hold,     32'd1);
    chk("rst_core_gnt", core_gnt, 32'd0);
    chk("rst_mem_en",   mem_en,   32'd0);

    // 1: core-only read
    step();
    rst = 1;
    @(negedge clk);
    chk("t1_gnt",  core_gnt, 32'd1);
    chk("t1_en",   mem_en,   32'd1);
    chk("t1_addr", mem_addr, 32'h010);
    chk("t1_hold", hold,     32'd0);
    step();
    core_req = 0;
    @(negedge clk);
    chk("t1_rvalid",  core_rvalid, 32'd1);
    chk("t1_rdata",   core_rdata,  32'hA500_0010);
    chk("t1_drvalid", dma_rvalid,  32'd0);

    // 2: contention without lock
    do_reset();
    core_req = 1; core_addr = 14'h001;
    dma_req  = 1; dma_addr  = 14'h002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_cgnt", core_gnt, 32'(i % 2 == 0));
      chk("t2_dgnt", dma_gnt,  32'(i % 2 == 1));
      chk("t2_hold", hold,     32'(i % 2 == 1));
      if (i > 0) chk("t2_crv", core_rvalid, 32'((i - 1) % 2 == 0));
      step();
    end
    clear_reqs();
    @(negedge clk);
    chk("t2_drv_last", dma_rvalid, 32'd1);

    // 3: burst lock
    do_reset();
    dma_req = 1; dma_lock = 1; dma_addr = 14'h003;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_dgnt", dma_gnt, 32'(exp_d[i]));
      if (i > 0) chk("t3_cgnt", core_gnt, 32'(1 - exp_d[i]));
      step();
      core_req = 1; core_addr = 14'h004;
    end
    clear_reqs();

    // 4: write/read mix
    do_reset();
    core_req = 1; core_we = 4'b0011; core_addr = 14'h020; core_wdata = 32'hDEAD_BEEF;
    dma_req  = 1; dma_we  = 4'b0000; dma_addr  = 14'h020;
    @(negedge clk);
    chk("t4_cgnt", core_gnt, 32'd1);
    chk("t4_we1",  mem_we,   32'h3);
    step();
    core_req = 0; core_we = 0;
    @(negedge clk);
    chk("t4_dgnt", dma_gnt, 32'd1);
    chk("t4_we2",  mem_we,  32'h0);
    step();
    dma_req = 0;
    @(negedge clk);
    chk("t4_drv",   dma_rvalid,  32'd1);
    chk("t4_crv",   core_rvalid, 32'd0);
    chk("t4_rdata", dma_rdata,   32'hA500_BEEF);

    // 5: reset mid-read
    do_reset();
    dma_req = 1; dma_addr = 14'h005;
    @(negedge clk);
    chk("t5_dgnt", dma_gnt, 32'd1);
    #2 rst = 0;
    @(negedge clk);
    chk("t5_drv_a", dma_rvalid, 32'd0);
    step();
    step();
    @(negedge clk);
    chk("t5_drv_b", dma_rvalid, 32'd0);
    step();
    rst = 1; core_req = 1; core_addr = 14'h006;
    @(negedge clk);
    chk("t5_first_core", core_gnt, 32'd1);

    // 6: idle preserves last owner
    step();
    core_req = 0;
    @(negedge clk);
    chk("t6_dgnt", dma_gnt, 32'd1);
    step();
    dma_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_en", mem_en, 32'd0);
      chk("t6_we", mem_we, 32'd0);
      if (i > 0) chk("t6_rv", {30'd0, core_rvalid, dma_rvalid}, 32'd0);
      step();
    end
    core_req = 1; dma_req = 1;
    @(negedge clk);
    chk("t6_next_core", core_gnt, 32'd1);
    clear_reqs();

    // randomized traffic
    do_reset();
    m_cg = 0; m_dg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!rst) rst = 1;
      else if ($urandom_range(0, 199) == 0) rst = 0;
      if (!core_req || m_cg) begin
        if ($urandom_range(0, 99) < 60) new_core(); else core_req = 0;
      end
      if (!dma_req || m_dg) begin
        if ($urandom_range(0, 99) < 70) new_dma(); else dma_req = 0;
      end
      dma_lock = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
